// File: rtl/time_set_ctrl.sv
// time_set_ctrl: enable/load sequencer for the sec/min/hr digit counters.
// Divides clk into a 1 Hz tick, gates carries with the counters' terminal-count
// flags, and runs a RUN/SET_MIN/SET_HR mode FSM with inc auto-repeat.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   btn_mode, btn_inc debounced button levels
//   sec_tc, min_tc    counter terminal-count flags (combinational from counters)
//   tick              1-cycle 1 Hz pulse (RUN only)
//   sec_ce, sec_ld    seconds enable / clear-load
//   min_ce, hr_ce     minutes / hours enable
//   mode              2'b00 RUN, 2'b01 SET_MIN, 2'b10 SET_HR
module time_set_ctrl #(
  parameter int unsigned DIV      = 12000000,
  parameter int unsigned FAST_DIV = 1200000,
  parameter int unsigned HOLD     = 6000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sec_tc,
  input  logic       min_tc,
  output logic       tick,
  output logic       sec_ce,
  output logic       sec_ld,
  output logic       min_ce,
  output logic       hr_ce,
  output logic [1:0] mode
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned HW = $clog2(HOLD + 1);
  localparam int unsigned RW = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_MIN = 2'b01,
    SET_HR  = 2'b10,
    BAD     = 2'b11
  } mode_e;

  mode_e         state, state_d;
  logic [PW-1:0] presc, presc_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [RW-1:0] rep_cnt, rep_d;
  logic          mode_prev, inc_prev;
  logic          tick_d, sec_ce_d, sec_ld_d, min_ce_d, hr_ce_d;
  logic          mode_edge, inc_edge, wrap, pulse;

  assign mode_edge = btn_mode & ~mode_prev;
  assign inc_edge  = btn_inc & ~inc_prev;

  // State, counters, edge history and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      presc     <= '0;
      hold_cnt  <= '0;
      rep_cnt   <= '0;
      mode_prev <= 1'b1;
      inc_prev  <= 1'b1;
      tick      <= 1'b0;
      sec_ce    <= 1'b0;
      sec_ld    <= 1'b0;
      min_ce    <= 1'b0;
      hr_ce     <= 1'b0;
    end else begin
      state     <= state_d;
      presc     <= presc_d;
      hold_cnt  <= hold_d;
      rep_cnt   <= rep_d;
      mode_prev <= btn_mode;
      inc_prev  <= btn_inc;
      tick      <= tick_d;
      sec_ce    <= sec_ce_d;
      sec_ld    <= sec_ld_d;
      min_ce    <= min_ce_d;
      hr_ce     <= hr_ce_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state;
    presc_d  = '0;
    hold_d   = '0;
    rep_d    = '0;
    tick_d   = 1'b0;
    sec_ce_d = 1'b0;
    sec_ld_d = 1'b0;
    min_ce_d = 1'b0;
    hr_ce_d  = 1'b0;
    wrap     = 1'b0;
    pulse    = 1'b0;
    case (state)
      RUN: begin
        if (mode_edge) begin
          // Entering SET_MIN clears the seconds counter once
          state_d  = SET_MIN;
          sec_ce_d = 1'b1;
          sec_ld_d = 1'b1;
        end else begin
          wrap     = (presc == PW'(DIV - 1));
          presc_d  = wrap ? '0 : presc + PW'(1);
          tick_d   = wrap;
          sec_ce_d = wrap;
          min_ce_d = wrap & sec_tc;
          hr_ce_d  = wrap & sec_tc & min_tc;
        end
      end
      SET_MIN, SET_HR: begin
        if (mode_edge) begin
          // Mode wins over inc; hold/repeat counters drop to zero
          state_d = (state == SET_MIN) ? SET_HR : RUN;
        end else if (btn_inc) begin
          // hold_cnt only runs after an accepted press, so a level held
          // through reset or a mode change never auto-repeats
          if (inc_edge) begin
            hold_d = HW'(1);
          end else if (hold_cnt != '0) begin
            hold_d = (hold_cnt == HW'(HOLD)) ? hold_cnt : hold_cnt + HW'(1);
          end
          if (hold_cnt == HW'(HOLD)) begin
            rep_d = (rep_cnt == RW'(FAST_DIV - 1)) ? '0 : rep_cnt + RW'(1);
          end
          pulse    = inc_edge | ((hold_cnt == HW'(HOLD)) & (rep_cnt == '0));
          min_ce_d = pulse & (state == SET_MIN);
          hr_ce_d  = pulse & (state == SET_HR);
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign mode = state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl: directed vector table plus randomized stimulus,
// both checked each cycle against a behavioural model.
module tb_time_set_ctrl;

  localparam int DIV      = 10;
  localparam int FAST_DIV = 4;
  localparam int HOLD     = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       sec_tc = 1'b0;
  logic       min_tc = 1'b0;
  logic       tick, sec_ce, sec_ld, min_ce, hr_ce;
  logic [1:0] mode;

  int tests = 0;
  int fails = 0;

  time_set_ctrl #(.DIV(DIV), .FAST_DIV(FAST_DIV), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_tc(sec_tc), .min_tc(min_tc), .tick(tick), .sec_ce(sec_ce),
    .sec_ld(sec_ld), .min_ce(min_ce), .hr_ce(hr_ce), .mode(mode)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode index, cycles spent in RUN since entry, and
  // cycles since the accepted inc press (-1 when no press is being held).
  int   m_mode = 0;
  int   run_age = 0;
  int   press_age = -1;
  logic m_pm = 1'b1;
  logic m_pi = 1'b1;

  typedef struct {
    int         n;
    logic       r, bm, bi, st, mt;
    logic [6:0] e;   // {tick, sec_ce, sec_ld, min_ce, hr_ce, mode}
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic r, bm, bi, st, mt,
                     input logic t, s, l, m, h, input logic [1:0] md);
    vec_t v;
    v.n = n; v.r = r; v.bm = bm; v.bi = bi; v.st = st; v.mt = mt;
    v.e = {t, s, l, m, h, md};
    tbl.push_back(v);
  endtask

  task automatic model(input logic r, bm, bi, st, mt, output logic [6:0] e);
    logic t, s, l, m, h, pulse;
    t = 0; s = 0; l = 0; m = 0; h = 0;
    if (r) begin
      m_mode = 0; run_age = 0; press_age = -1; m_pm = 1'b1; m_pi = 1'b1;
    end else begin
      if (bm && !m_pm) begin
        s = (m_mode == 0);
        l = s;
        m_mode = (m_mode + 1) % 3;
        run_age = 0;
        press_age = -1;
      end else if (m_mode == 0) begin
        t = ((run_age % DIV) == DIV - 1);
        s = t;
        m = t && st;
        h = t && st && mt;
        run_age++;
        press_age = -1;
      end else begin
        if (!bi) press_age = -1;
        else if (!m_pi) press_age = 0;
        else if (press_age >= 0) press_age++;
        pulse = (press_age == 0) ||
                (press_age >= HOLD && ((press_age - HOLD) % FAST_DIV) == 0);
        m = pulse && (m_mode == 1);
        h = pulse && (m_mode == 2);
      end
      m_pm = bm;
      m_pi = bi;
    end
    e = {t, s, l, m, h, 2'(m_mode)};
  endtask

  // One clock: drive inputs, predict, clock, sample #1 after the edge, compare
  task automatic step(input logic r, bm, bi, st, mt, output logic [6:0] got);
    logic [6:0] e;
    rst = r; btn_mode = bm; btn_inc = bi; sec_tc = st; min_tc = mt;
    model(r, bm, bi, st, mt, e);
    @(posedge clk);
    #1;
    got = {tick, sec_ce, sec_ld, min_ce, hr_ce, mode};
    tests++;
    if (got !== e) begin
      fails++;
      $display("FAIL model t=%0t got {tick,sce,sld,mce,hce,mode}=%b expected %b", $time, got, e);
    end
  endtask

  initial begin
    logic [6:0] got;
    logic       rb, mb, ib;

    //   n  r bm bi st mt   t s l m h mode
    add( 2, 1, 0, 0, 0, 0,  0,0,0,0,0, 2'b00);  // reset
    add( 9, 0, 0, 0, 0, 0,  0,0,0,0,0, 2'b00);
    add( 1, 0, 0, 0, 0, 0,  1,1,0,0,0, 2'b00);  // first tick at cycle 10
    add( 1, 0, 0, 0, 0, 0,  0,0,0,0,0, 2'b00);
    add( 8, 0, 0, 0, 0, 0,  0,0,0,0,0, 2'b00);
    add( 1, 0, 0, 0, 0, 0,  1,1,0,0,0, 2'b00);  // cycle 20
    add( 9, 0, 0, 0, 1, 0,  0,0,0,0,0, 2'b00);
    add( 1, 0, 0, 0, 1, 0,  1,1,0,1,0, 2'b00);  // seconds carry
    add( 9, 0, 0, 0, 1, 1,  0,0,0,0,0, 2'b00);
    add( 1, 0, 0, 0, 1, 1,  1,1,0,1,1, 2'b00);  // double carry
    add( 1, 0, 1, 0, 0, 0,  0,1,1,0,0, 2'b01);  // enter SET_MIN clears sec
    add( 1, 0, 0, 0, 0, 0,  0,0,0,0,0, 2'b01);
    add( 1, 0, 1, 0, 0, 0,  0,0,0,0,0, 2'b10);
    add( 1, 0, 0, 0, 0, 0,  0,0,0,0,0, 2'b10);
    add( 1, 0, 1, 0, 0, 0,  0,0,0,0,0, 2'b00);  // back to RUN
    add( 9, 0, 0, 0, 0, 0,  0,0,0,0,0, 2'b00);
    add( 1, 0, 0, 0, 0, 0,  1,1,0,0,0, 2'b00);  // full period after re-entry
    add( 1, 0, 1, 0, 0, 0,  0,1,1,0,0, 2'b01);
    add( 1, 0, 0, 0, 0, 0,  0,0,0,0,0, 2'b01);
    add( 1, 0, 0, 1, 0, 0,  0,0,0,1,0, 2'b01);  // press: +1
    add( 7, 0, 0, 1, 0, 0,  0,0,0,0,0, 2'b01);
    add( 1, 0, 0, 1, 0, 0,  0,0,0,1,0, 2'b01);  // +9
    add( 3, 0, 0, 1, 0, 0,  0,0,0,0,0, 2'b01);
    add( 1, 0, 0, 1, 0, 0,  0,0,0,1,0, 2'b01);  // +13
    add( 3, 0, 0, 1, 0, 0,  0,0,0,0,0, 2'b01);
    add( 1, 0, 0, 1, 0, 0,  0,0,0,1,0, 2'b01);  // +17
    add( 3, 0, 0, 1, 0, 0,  0,0,0,0,0, 2'b01);
    add( 4, 0, 0, 0, 0, 0,  0,0,0,0,0, 2'b01);  // released
    add( 1, 0, 1, 1, 0, 0,  0,0,0,0,0, 2'b10);  // mode wins over inc
    add( 1, 0, 0, 1, 0, 0,  0,0,0,0,0, 2'b10);
    add( 1, 0, 0, 0, 0, 0,  0,0,0,0,0, 2'b10);
    add( 1, 0, 0, 1, 0, 0,  0,0,0,0,1, 2'b10);  // hr press
    add( 9, 0, 0, 1, 0, 0,  0,0,0,0,0, 2'b10);  // in auto-repeat
    add( 1, 1, 0, 1, 0, 0,  0,0,0,0,0, 2'b00);  // reset mid-repeat
    add( 1, 0, 0, 1, 0, 0,  0,0,0,0,0, 2'b00);
    add( 1, 0, 1, 1, 0, 0,  0,1,1,0,0, 2'b01);
    add(12, 0, 0, 1, 0, 0,  0,0,0,0,0, 2'b01);  // held through reset: silent
    add( 1, 0, 0, 0, 0, 0,  0,0,0,0,0, 2'b01);
    add( 1, 0, 0, 1, 0, 0,  0,0,0,1,0, 2'b01);  // re-press pulses

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++)
        step(tbl[i].r, tbl[i].bm, tbl[i].bi, tbl[i].st, tbl[i].mt, got);
      tests++;
      if (got !== tbl[i].e) begin
        fails++;
        $display("FAIL vec%0d got {tick,sce,sld,mce,hce,mode}=%b expected %b", i, got, tbl[i].e);
      end
    end

    // Randomized phase: slowly toggling buttons exercise holds and repeats
    mb = 1'b0;
    ib = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rb = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) mb = ~mb;
      if ($urandom_range(0, 23) == 0) ib = ~ib;
      step(rb, mb, ib, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
